// File: rtl/fetch_controller_if.sv
// fetch_controller_if: instruction-memory request/response handshake
interface fetch_controller_if;
  logic        req;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  modport master (output req, input gnt, input rvalid, input rdata);
  modport slave (input req, output gnt, output rvalid, output rdata);
endinterface

// File: rtl/fetch_controller.sv
// fetch_controller: fetch-stage PC sequencing, imem handshake and instruction hold
module fetch_controller #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  fetch_controller_if.master   imem,
  input  logic [31:0]          F_pc_current,
  input  logic                 E_branch_jal_taken,
  input  logic                 E_jalr_taken,
  input  logic                 D_ready,
  output logic                 F_pc_en,
  output logic [1:0]           F_pc_src_sel,
  output logic [31:0]          F_instr,
  output logic [31:0]          F_instr_pc,
  output logic                 F_instr_valid,
  output logic [CNT_WIDTH-1:0] fetch_cnt
);
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] REQ  = 3'd1;
  localparam logic [2:0] WAIT = 3'd2;
  localparam logic [2:0] HOLD = 3'd3;
  localparam logic [2:0] DROP = 3'd4;
  logic [2:0] state;
  logic       redirect;
  logic       granted;
  assign redirect     = E_branch_jal_taken | E_jalr_taken;
  assign imem.req     = ~redirect & ((state == REQ) | ((state == HOLD) & D_ready));
  assign granted      = imem.req & imem.gnt;
  assign F_pc_en      = redirect | granted;
  assign F_pc_src_sel = E_branch_jal_taken ? 2'b01 : E_jalr_taken ? 2'b10 : 2'b00;
  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      F_instr       <= NOP_INSTR;
      F_instr_pc    <= '0;
      F_instr_valid <= 1'b0;
      fetch_cnt     <= '0;
    end else begin
      if (granted) F_instr_pc <= F_pc_current;
      case (state)
        IDLE: state <= REQ;
        REQ: state <= granted ? WAIT : REQ;
        WAIT: begin
          if (imem.rvalid && !redirect) begin
            F_instr       <= imem.rdata;
            F_instr_valid <= 1'b1;
            state         <= HOLD;
          end else if (redirect) begin
            state <= imem.rvalid ? REQ : DROP;
          end
        end
        // the response owed to a pre-redirect request is swallowed here
        DROP: state <= imem.rvalid ? REQ : DROP;
        HOLD: begin
          if (redirect) begin
            F_instr       <= NOP_INSTR;
            F_instr_valid <= 1'b0;
            state         <= REQ;
          end else if (D_ready) begin
            fetch_cnt     <= fetch_cnt + 1'b1;
            F_instr_valid <= 1'b0;
            state         <= granted ? WAIT : REQ;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_controller.sv
// tb_fetch_controller: directed checks of fetch_controller
module tb_fetch_controller;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic        br, jalr, d_ready;
  logic        pc_en;
  logic [1:0]  sel;
  logic [31:0] instr, instr_pc, cnt;
  logic        valid;
  int          tests = 0;
  int          failed = 0;
  fetch_controller_if imem ();
  fetch_controller dut (
    .clk(clk), .reset(reset), .imem(imem), .F_pc_current(pc),
    .E_branch_jal_taken(br), .E_jalr_taken(jalr), .D_ready(d_ready),
    .F_pc_en(pc_en), .F_pc_src_sel(sel), .F_instr(instr), .F_instr_pc(instr_pc),
    .F_instr_valid(valid), .fetch_cnt(cnt)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  initial begin
    reset = 1'b0; pc = 32'h8000_0000; br = 0; jalr = 0; d_ready = 0;
    imem.gnt = 0; imem.rvalid = 0; imem.rdata = '0;
    tick(); #1;
    chk("rst_instr", instr, 32'h13);
    chk("rst_valid", {31'd0, valid}, 0);
    chk("rst_cnt", cnt, 0);
    chk("rst_ipc", instr_pc, 0);
    chk("rst_req", {31'd0, imem.req}, 0);
    reset = 1; imem.gnt = 1; d_ready = 1;
    tick(); #1;
    chk("c1_req", {31'd0, imem.req}, 1);
    chk("c1_pcen", {31'd0, pc_en}, 1);
    chk("c1_sel", {30'd0, sel}, 0);
    tick(); pc = 32'h8000_0004; imem.rvalid = 1; imem.rdata = 32'h0010_0093; #1;
    chk("wait_req", {31'd0, imem.req}, 0);
    chk("wait_pcen", {31'd0, pc_en}, 0);
    tick(); imem.rvalid = 0; #1;
    chk("i0_valid", {31'd0, valid}, 1);
    chk("i0_instr", instr, 32'h0010_0093);
    chk("i0_pc", instr_pc, 32'h8000_0000);
    chk("i0_req", {31'd0, imem.req}, 1);
    tick(); pc = 32'h8000_0008; imem.rvalid = 1; imem.rdata = 32'h0020_0113; #1;
    chk("cnt1", cnt, 1);
    chk("i1_reqpc", instr_pc, 32'h8000_0004);
    chk("i1_vld0", {31'd0, valid}, 0);
    tick(); imem.rvalid = 0; #1;
    chk("i1_instr", instr, 32'h0020_0113);
    chk("i1_pc", instr_pc, 32'h8000_0004);
    tick(); pc = 32'h8000_000C; imem.rvalid = 1; imem.rdata = 32'h0030_0193; imem.gnt = 0; #1;
    chk("i2_reqpc", instr_pc, 32'h8000_0008);
    tick(); imem.rvalid = 0; #1;
    chk("i2_instr", instr, 32'h0030_0193);
    chk("i2_req_nognt", {31'd0, imem.req}, 1);
    chk("i2_pcen_nognt", {31'd0, pc_en}, 0);
    tick(); #1;
    chk("cnt3", cnt, 3);
    chk("i2_vld0", {31'd0, valid}, 0);
    for (int i = 0; i < 5; i++) begin
      chk("stall_req", {31'd0, imem.req}, 1);
      chk("stall_pcen", {31'd0, pc_en}, 0);
      tick(); #1;
    end
    imem.gnt = 1; #1;
    chk("stall_gnt_pcen", {31'd0, pc_en}, 1);
    tick(); pc = 32'h8000_0010; d_ready = 0; imem.rvalid = 1; imem.rdata = 32'h0040_0213; #1;
    chk("i3_reqpc", instr_pc, 32'h8000_000C);
    tick(); imem.rvalid = 0; #1;
    for (int i = 0; i < 4; i++) begin
      chk("hold_req", {31'd0, imem.req}, 0);
      chk("hold_instr", instr, 32'h0040_0213);
      chk("hold_pc", instr_pc, 32'h8000_000C);
      chk("hold_valid", {31'd0, valid}, 1);
      chk("hold_cnt", cnt, 3);
      tick(); #1;
    end
    d_ready = 1; #1;
    chk("rel_req", {31'd0, imem.req}, 1);
    chk("rel_pcen", {31'd0, pc_en}, 1);
    tick(); pc = 32'h8000_0014; #1;
    chk("cnt4", cnt, 4);
    chk("i4_reqpc", instr_pc, 32'h8000_0010);
    jalr = 1; #1;
    chk("jalr_pcen", {31'd0, pc_en}, 1);
    chk("jalr_sel", {30'd0, sel}, 2'b10);
    chk("jalr_req", {31'd0, imem.req}, 0);
    tick(); jalr = 0; pc = 32'h8000_0100; #1;
    chk("drop_req", {31'd0, imem.req}, 0);
    chk("drop_pcen", {31'd0, pc_en}, 0);
    tick(); imem.rvalid = 1; imem.rdata = 32'hDEAD_BEEF; #1;
    chk("drop_req2", {31'd0, imem.req}, 0);
    tick(); imem.rvalid = 0; #1;
    chk("drop_valid", {31'd0, valid}, 0);
    chk("drop_instr", instr, 32'h0040_0213);
    chk("drop_newreq", {31'd0, imem.req}, 1);
    chk("drop_newsel", {30'd0, sel}, 0);
    tick(); pc = 32'h8000_0104; d_ready = 0; imem.rvalid = 1; imem.rdata = 32'h0050_0293; #1;
    chk("tgt_reqpc", instr_pc, 32'h8000_0100);
    tick(); imem.rvalid = 0; #1;
    chk("tgt_valid", {31'd0, valid}, 1);
    br = 1; jalr = 1; d_ready = 1; #1;
    chk("both_sel", {30'd0, sel}, 2'b01);
    chk("both_pcen", {31'd0, pc_en}, 1);
    chk("both_req", {31'd0, imem.req}, 0);
    tick(); br = 0; jalr = 0; pc = 32'h8000_0200; #1;
    chk("kill_valid", {31'd0, valid}, 0);
    chk("kill_instr", instr, 32'h13);
    chk("kill_cnt", cnt, 4);
    tick(); imem.gnt = 0; reset = 0; #1;
    chk("w_reqpc", instr_pc, 32'h8000_0200);
    tick(); reset = 1; #1;
    chk("r2_valid", {31'd0, valid}, 0);
    chk("r2_instr", instr, 32'h13);
    chk("r2_ipc", instr_pc, 0);
    chk("r2_cnt", cnt, 0);
    tick(); imem.rvalid = 1; imem.rdata = 32'hBAD0_BAD0; #1;
    chk("r2_req", {31'd0, imem.req}, 1);
    tick(); imem.rvalid = 0; #1;
    chk("stray_valid", {31'd0, valid}, 0);
    chk("stray_instr", instr, 32'h13);
    imem.gnt = 1; #1;
    chk("resume_pcen", {31'd0, pc_en}, 1);
    tick(); imem.rvalid = 1; imem.rdata = 32'h0060_0313; #1;
    chk("resume_reqpc", instr_pc, 32'h8000_0200);
    tick(); imem.rvalid = 0; imem.gnt = 0; #1;
    chk("resume_instr", instr, 32'h0060_0313);
    chk("resume_valid", {31'd0, valid}, 1);
    tick(); #1;
    chk("resume_cnt", cnt, 1);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
